// File: rtl/arf_rename_table.sv
// rtl/arf_rename_table.sv - architectural register file with per-register rename (busy/tag) state.
// Define ARF_CDB_BYPASS_EN to forward a matching CDB broadcast onto the read ports in the same cycle.
module arf_rename_table #(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int AW         = $clog2(NUM_REGS),
    parameter int CW         = $clog2(NUM_REGS) + 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [AW-1:0]         READ_REG1,
    input  logic [AW-1:0]         READ_REG2,
    output logic [DATA_WIDTH-1:0] READ_DATA1,
    output logic [DATA_WIDTH-1:0] READ_DATA2,
    output logic                  READ_BUSY1,
    output logic                  READ_BUSY2,
    output logic [TAG_WIDTH-1:0]  READ_TAG1,
    output logic [TAG_WIDTH-1:0]  READ_TAG2,
    input  logic                  RENAME_ENABLE,
    input  logic [AW-1:0]         RENAME_REG,
    input  logic [TAG_WIDTH-1:0]  RENAME_TAG,
    input  logic                  CDB_VALID,
    input  logic [TAG_WIDTH-1:0]  CDB_TAG,
    input  logic [DATA_WIDTH-1:0] CDB_DATA,
    input  logic                  FLUSH,
    output logic [CW-1:0]         BUSY_COUNT
);

    logic [DATA_WIDTH-1:0] data_q [NUM_REGS];
    logic [TAG_WIDTH-1:0]  tag_q  [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [CW-1:0]         count_q;

    logic [DATA_WIDTH-1:0] data_d [NUM_REGS];
    logic [TAG_WIDTH-1:0]  tag_d  [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_d;
    logic [CW-1:0]         count_d;

    // Register 0 is never written, so it stays at its reset value of all zeros.
    always_comb begin
        count_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            data_d[r] = data_q[r];
            tag_d[r]  = tag_q[r];
            busy_d[r] = busy_q[r];
            if (r != 0) begin
                if (CDB_VALID && busy_q[r] && (tag_q[r] == CDB_TAG)) begin
                    data_d[r] = CDB_DATA;
                    busy_d[r] = 1'b0;
                end
                // A rename to the register the CDB just retired re-arms it with the new tag.
                if (RENAME_ENABLE && !FLUSH && (RENAME_REG == AW'(r))) begin
                    busy_d[r] = 1'b1;
                    tag_d[r]  = RENAME_TAG;
                end
                if (FLUSH) begin
                    busy_d[r] = 1'b0;
                end
            end
            count_d = count_d + CW'(busy_d[r]);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
            end
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                data_q[r] <= data_d[r];
                tag_q[r]  <= tag_d[r];
            end
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign BUSY_COUNT = count_q;

    always_comb begin
        READ_DATA1 = data_q[READ_REG1];
        READ_BUSY1 = busy_q[READ_REG1];
        READ_TAG1  = tag_q[READ_REG1];
        READ_DATA2 = data_q[READ_REG2];
        READ_BUSY2 = busy_q[READ_REG2];
        READ_TAG2  = tag_q[READ_REG2];
`ifdef ARF_CDB_BYPASS_EN
        if ((READ_REG1 != '0) && busy_q[READ_REG1] && CDB_VALID && (tag_q[READ_REG1] == CDB_TAG)) begin
            READ_DATA1 = CDB_DATA;
            READ_BUSY1 = 1'b0;
        end
        if ((READ_REG2 != '0) && busy_q[READ_REG2] && CDB_VALID && (tag_q[READ_REG2] == CDB_TAG)) begin
            READ_DATA2 = CDB_DATA;
            READ_BUSY2 = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_arf_rename_table.sv
// tb/tb_arf_rename_table.sv - directed self-checking bench for arf_rename_table.
module tb_arf_rename_table;

    localparam int AW = 4;
    localparam int CW = 5;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  READ_REG1, READ_REG2;
    logic [31:0] READ_DATA1, READ_DATA2;
    logic        READ_BUSY1, READ_BUSY2;
    logic [3:0]  READ_TAG1, READ_TAG2;
    logic        RENAME_ENABLE;
    logic [3:0]  RENAME_REG;
    logic [3:0]  RENAME_TAG;
    logic        CDB_VALID;
    logic [3:0]  CDB_TAG;
    logic [31:0] CDB_DATA;
    logic        FLUSH;
    logic [CW-1:0] BUSY_COUNT;

    int n_checks = 0;
    int n_errors = 0;

    arf_rename_table #(.NUM_REGS(16), .DATA_WIDTH(32), .TAG_WIDTH(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .READ_REG1(READ_REG1), .READ_REG2(READ_REG2),
        .READ_DATA1(READ_DATA1), .READ_DATA2(READ_DATA2),
        .READ_BUSY1(READ_BUSY1), .READ_BUSY2(READ_BUSY2),
        .READ_TAG1(READ_TAG1), .READ_TAG2(READ_TAG2),
        .RENAME_ENABLE(RENAME_ENABLE), .RENAME_REG(RENAME_REG), .RENAME_TAG(RENAME_TAG),
        .CDB_VALID(CDB_VALID), .CDB_TAG(CDB_TAG), .CDB_DATA(CDB_DATA),
        .FLUSH(FLUSH), .BUSY_COUNT(BUSY_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rename(input logic [3:0] r, input logic [3:0] t);
        RENAME_ENABLE = 1'b1; RENAME_REG = r; RENAME_TAG = t;
        tick();
        RENAME_ENABLE = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] d);
        CDB_VALID = 1'b1; CDB_TAG = t; CDB_DATA = d;
        tick();
        CDB_VALID = 1'b0;
    endtask

    task automatic look(input logic [3:0] r);
        READ_REG1 = r; READ_REG2 = r;
        #1;
    endtask

    initial begin
        RESET = 1'b0; READ_REG1 = '0; READ_REG2 = '0;
        RENAME_ENABLE = 1'b0; RENAME_REG = '0; RENAME_TAG = '0;
        CDB_VALID = 1'b0; CDB_TAG = '0; CDB_DATA = '0; FLUSH = 1'b0;
        tick(); tick();
        RESET = 1'b1;

        for (int r = 0; r < 16; r++) begin
            READ_REG1 = 4'(r); READ_REG2 = 4'(15 - r);
            #1;
            check("rst_data1", READ_DATA1, 0);
            check("rst_busy1", READ_BUSY1, 0);
            check("rst_busy2", READ_BUSY2, 0);
        end
        check("rst_count", BUSY_COUNT, 0);

        rename(4'd5, 4'd3);
        look(4'd5);
        check("ren_busy", READ_BUSY1, 1);
        check("ren_tag", READ_TAG1, 3);
        check("ren_tag2", READ_TAG2, 3);
        check("ren_count", BUSY_COUNT, 1);
        cdb(4'd3, 32'hDEADBEEF);
        check("ret_data", READ_DATA1, 32'hDEADBEEF);
        check("ret_busy", READ_BUSY1, 0);
        check("ret_count", BUSY_COUNT, 0);

        rename(4'd7, 4'd2);
        rename(4'd7, 4'd9);
        cdb(4'd2, 32'h11);
        look(4'd7);
        check("stale_busy", READ_BUSY1, 1);
        check("stale_tag", READ_TAG1, 9);
        check("stale_data", READ_DATA1, 0);
        check("stale_count", BUSY_COUNT, 1);
        cdb(4'd9, 32'h22);
        check("fresh_data", READ_DATA1, 32'h22);
        check("fresh_busy", READ_BUSY1, 0);
        check("fresh_count", BUSY_COUNT, 0);

        rename(4'd4, 4'd1);
        RENAME_ENABLE = 1'b1; RENAME_REG = 4'd4; RENAME_TAG = 4'd6;
        cdb(4'd1, 32'h55);
        RENAME_ENABLE = 1'b0;
        look(4'd4);
        check("sim_data", READ_DATA1, 32'h55);
        check("sim_busy", READ_BUSY1, 1);
        check("sim_tag", READ_TAG1, 6);
        check("sim_count", BUSY_COUNT, 1);
        cdb(4'd6, 32'h66);
        check("sim_ret_data", READ_DATA1, 32'h66);
        check("sim_ret_count", BUSY_COUNT, 0);

        RENAME_ENABLE = 1'b1; RENAME_REG = 4'd0; RENAME_TAG = 4'd5;
        cdb(4'd5, 32'h77);
        RENAME_ENABLE = 1'b0;
        look(4'd0);
        check("r0_data", READ_DATA1, 0);
        check("r0_busy", READ_BUSY1, 0);
        check("r0_tag", READ_TAG1, 0);
        check("r0_count", BUSY_COUNT, 0);

        rename(4'd1, 4'd1);
        rename(4'd2, 4'd2);
        rename(4'd3, 4'd3);
        check("pre_flush_count", BUSY_COUNT, 3);
        FLUSH = 1'b1;
        rename(4'd8, 4'd8);
        FLUSH = 1'b0;
        check("flush_count", BUSY_COUNT, 0);
        for (int r = 1; r <= 3; r++) begin
            look(4'(r));
            check("flush_busy", READ_BUSY1, 0);
            check("flush_tag_kept", READ_TAG1, 64'(r));
        end
        look(4'd8);
        check("flush_r8_busy", READ_BUSY1, 0);
        look(4'd5);
        check("flush_r5_data", READ_DATA1, 32'hDEADBEEF);
        look(4'd4);
        check("flush_r4_data", READ_DATA1, 32'h66);

        rename(4'd9, 4'd11);
        FLUSH = 1'b1;
        cdb(4'd11, 32'h99);
        FLUSH = 1'b0;
        look(4'd9);
        check("flush_cdb_data", READ_DATA1, 32'h99);
        check("flush_cdb_busy", READ_BUSY1, 0);

        rename(4'd10, 4'd4);
        look(4'd10);
        CDB_VALID = 1'b1; CDB_TAG = 4'd4; CDB_DATA = 32'hA5A5A5A5;
        #1;
`ifdef ARF_CDB_BYPASS_EN
        check("byp_data", READ_DATA1, 32'hA5A5A5A5);
        check("byp_busy", READ_BUSY1, 0);
        check("byp_busy2", READ_BUSY2, 0);
`else
        check("nobyp_data", READ_DATA1, 0);
        check("nobyp_busy", READ_BUSY1, 1);
        check("nobyp_tag", READ_TAG1, 4);
`endif
        tick();
        CDB_VALID = 1'b0;
        #1;
        check("byp_after_data", READ_DATA2, 32'hA5A5A5A5);
        check("byp_after_busy", READ_BUSY2, 0);

        rename(4'd6, 4'd7);
        check("mid_pre_count", BUSY_COUNT, 1);
        RESET = 1'b0;
        rename(4'd11, 4'd2);
        RESET = 1'b1;
        check("mid_rst_count", BUSY_COUNT, 0);
        look(4'd6);
        check("mid_rst_busy6", READ_BUSY1, 0);
        look(4'd11);
        check("mid_rst_busy11", READ_BUSY1, 0);
        look(4'd5);
        check("mid_rst_data5", READ_DATA1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/arf_rename_table.md
# arf_rename_table

Parametrised architecture register file with per-register rename state for the superscalar core's Tomasulo-style issue path. Each architectural register holds a value, a busy bit and the tag of its pending producer. Dispatch renames a destination register to a reservation-station tag. The common data bus (CDB) retires the result into the register only if its tag is still the one recorded. Source reads return either the committed value or the tag to wait on.

## Interface
Parameters:
- NUM_REGS, 16: number of architectural registers; power of two, at least 2
- DATA_WIDTH, 32: register value width
- TAG_WIDTH, 4: reservation-station tag width
- Derived: AW = $clog2(NUM_REGS); CW = $clog2(NUM_REGS)+1

Ports:
- Clock and reset (already decided): one clock, CLK; reset RESET is synchronous and active-low.
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  synchronous reset, active-low
- READ_REG1, READ_REG2  in  AW  source register indices
- READ_DATA1, READ_DATA2  out  DATA_WIDTH  committed register value
- READ_BUSY1, READ_BUSY2  out  1  register awaits a producer
- READ_TAG1, READ_TAG2  out  TAG_WIDTH  pending producer tag; valid only when busy
- RENAME_ENABLE  in  1  dispatch allocates a destination this cycle
- RENAME_REG  in  AW  destination register
- RENAME_TAG  in  TAG_WIDTH  tag of the allocated reservation station
- CDB_VALID  in  1  result broadcast this cycle
- CDB_TAG  in  TAG_WIDTH  broadcasting producer tag
- CDB_DATA  in  DATA_WIDTH  broadcast result
- FLUSH  in  1  misprediction recovery; clears all busy bits
- BUSY_COUNT  out  CW  number of busy registers

## Operation
- Read ports are combinational from current state and are independent of each other.
- Register 0 is hardwired:
  - it reads data 0, busy 0, tag 0;
  - renames and CDB writes that target it are ignored;
  - it is never counted in BUSY_COUNT.
- Rename, when RENAME_ENABLE=1 and RENAME_REG≠0: busy[RENAME_REG]←1 and tag[RENAME_REG]←RENAME_TAG. The data field is unchanged.
- CDB update, when CDB_VALID=1: every register r≠0 with busy[r]=1 and tag[r]=CDB_TAG gets data[r]←CDB_DATA and busy[r]←0.
  - Registers whose tag differs are untouched (stale producer).
  - Non-busy registers are never written.
- Rename and CDB hitting the same register in the same cycle:
  - data takes CDB_DATA;
  - busy stays 1;
  - tag takes RENAME_TAG (the rename wins).
- FLUSH=1 clears every busy bit and keeps data and tags.
  - A rename in the same cycle is discarded.
  - A CDB data write in the same cycle still happens for matching registers.
- BUSY_COUNT is a registered population count of the busy vector. It always matches the busy state visible on the read ports.
- No tag uniqueness checking: software and the issue logic guarantee that a live tag maps to at most one register.

## Timing
- Reset (RESET=0 at a rising edge):
  - all data, tags and busy bits become 0 and BUSY_COUNT becomes 0;
  - reset overrides rename, CDB and FLUSH in that cycle;
  - asserting reset mid-operation discards all pending renames.
- Read latency is 0 cycles: combinational from the state registers.
- Rename and CDB effects become visible on the read ports and on BUSY_COUNT the cycle after the edge that samples them.
- Without bypass, a read in the same cycle as a matching CDB returns the old state: busy=1 with the old tag. Issue logic must snoop the CDB itself.
- Throughput: one rename and one CDB broadcast per cycle, with no stalls.

## Configuration
- The macro ARF_CDB_BYPASS_EN adds same-cycle bypass on both read ports.
- Defined: if the addressed register is busy, CDB_VALID=1 and its tag equals CDB_TAG, the read port returns DATA=CDB_DATA and BUSY=0 combinationally in the same cycle.
  - The bypass does not apply to register 0.
  - A same-cycle rename does not affect read outputs until the next cycle.
- Undefined: read ports reflect only registered state. State-update behaviour is identical in both builds.

## Test plan
- Reset: hold RESET=0 for 2 cycles, then read registers 0–15 -> all data 0, busy 0, BUSY_COUNT=0.
- Rename then retire:
  - rename r5 with tag 3 -> next cycle READ_BUSY=1, READ_TAG=3, BUSY_COUNT=1;
  - then CDB tag 3 with data 0xDEADBEEF -> next cycle data 0xDEADBEEF, busy 0, BUSY_COUNT=0.
- Stale producer: rename r7 with tag 2, then rename r7 with tag 9, then CDB tag 2 with data 0x11 -> r7 stays busy with tag 9 and its data unchanged; CDB tag 9 with data 0x22 -> r7 data 0x22, not busy.
- Simultaneous events:
  - r4 busy with tag 1, then in one cycle a rename of r4 to tag 6 plus CDB tag 1 with data 0x55 -> r4 data 0x55, busy 1, tag 6;
  - rename of r0 plus CDB to r0 -> r0 still reads 0 with busy 0.
- Flush: rename r1, r2 and r3, then assert FLUSH together with a rename of r8 -> all busy bits 0 and BUSY_COUNT=0, r8 not busy, data preserved.
- Bypass (ARF_CDB_BYPASS_EN): r10 busy with tag 4, CDB tag 4 with data 0xA5A5A5A5 while reading r10 -> the same cycle shows data 0xA5A5A5A5 with busy 0. Without the macro the same stimulus shows busy 1 with tag 4.
